// File: rtl/req_handshake_tx.sv
// Source side of a 4-phase req/ack handshake: queues single-cycle events and launches one handshake per event.
// Outputs are registered; events arriving while a handshake is in flight wait in a saturating pending counter.
module req_handshake_tx #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 3,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              event_in,
  input  logic              ack_async,
  input  logic              clr_err,
  output logic              req_out,
  output logic              busy,
  output logic              done,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic              timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [TMO_W-1:0]  TMO_LIM  = TMO_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, REQ, REL} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;
  logic [PEND_W-1:0]      pend_q, pend_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                   req_q, busy_q, done_q, ovf_q, tmo_q;
  logic                   launch, ovf_set, tmo_set;

  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      IDLE: if (pend_q != '0 && !ack_s) begin
        launch  = 1'b1;
        state_d = REQ;
      end
      REQ:     if (ack_s)  state_d = REL;
      REL:     if (!ack_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A launch and a new event in the same cycle cancel out.
  always_comb begin
    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (event_in && !launch) begin
      if (pend_q == PEND_MAX) ovf_set = 1'b1;
      else                    pend_d  = pend_q + PEND_W'(1);
    end else if (!event_in && launch) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_set   = 1'b0;
    if (state_d != state_q) begin
      tmo_cnt_d = '0;
    end else if (state_q != IDLE && tmo_cnt_q != TMO_LIM) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      tmo_set   = (tmo_cnt_d == TMO_LIM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync_q <= '0;
      state_q    <= IDLE;
      pend_q     <= '0;
      tmo_cnt_q  <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_async};
      state_q    <= state_d;
      pend_q     <= pend_d;
      tmo_cnt_q  <= tmo_cnt_d;
      req_q      <= (state_d == REQ);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_q == REL) && (state_d == IDLE);
      // A set in the same cycle as clr_err takes priority.
      ovf_q      <= ovf_set | (ovf_q & ~clr_err);
      tmo_q      <= tmo_set | (tmo_q & ~clr_err);
    end
  end

  assign req_out     = req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pending     = pend_q;
  assign overflow    = ovf_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_req_handshake_tx.sv
// Bench for req_handshake_tx: vector table, directed corner sequences and a random run against a rule-level model.
module tb_req_handshake_tx;
  localparam int SYNC = 2;
  localparam int PW   = 3;
  localparam int TMO  = 15;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk, rst, event_in, ack_async, clr_err;
  logic          req_out, busy, done, overflow, timeout_err;
  logic [PW-1:0] pending;

  req_handshake_tx #(.SYNC_STAGES(SYNC), .PEND_W(PW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .event_in(event_in), .ack_async(ack_async), .clr_err(clr_err),
    .req_out(req_out), .busy(busy), .done(done), .pending(pending),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = idle, 1 = requesting, 2 = releasing.
  int m_phase = 0, m_pend = 0, m_tcnt = 0;
  bit m_ovf = 0, m_tmo = 0, m_done = 0;
  bit m_hist [SYNC];

  task automatic model_update();
    bit acks, launch, set_ovf, set_tmo;
    int np, nph;
    if (rst) begin
      m_phase = 0; m_pend = 0; m_tcnt = 0; m_ovf = 0; m_tmo = 0; m_done = 0;
      for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
      return;
    end
    acks    = m_hist[SYNC-1];
    launch  = (m_phase == 0) && (m_pend > 0) && !acks;
    np      = m_pend + int'(event_in) - int'(launch);
    set_ovf = (np > PMAX);
    if (set_ovf) np = PMAX;
    nph = m_phase;
    if (launch)                    nph = 1;
    else if (m_phase == 1 && acks)  nph = 2;
    else if (m_phase == 2 && !acks) nph = 0;
    m_done  = (m_phase == 2) && (nph == 0);
    set_tmo = (nph == m_phase) && (m_phase != 0) && (m_tcnt == TMO - 1);
    if (nph != m_phase)                   m_tcnt = 0;
    else if (m_phase != 0 && m_tcnt < TMO) m_tcnt++;
    m_ovf   = set_ovf | (m_ovf & !clr_err);
    m_tmo   = set_tmo | (m_tmo & !clr_err);
    m_phase = nph;
    m_pend  = np;
    for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = ack_async;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("model.req_out",     req_out,     int'(m_phase == 1));
    chk("model.busy",        busy,        int'(m_phase != 0));
    chk("model.done",        done,        m_done);
    chk("model.pending",     pending,     m_pend);
    chk("model.overflow",    overflow,    m_ovf);
    chk("model.timeout_err", timeout_err, m_tmo);
  endtask

  // Responder: ack follows req_out three cycles late.
  logic [2:0] rq;
  task automatic run_resp(input int n, output int dones);
    dones = 0;
    rq = '0;
    for (int i = 0; i < n; i++) begin
      step();
      if (done) dones++;
      rq = {rq[1:0], req_out};
      ack_async = rq[2];
    end
  endtask

  typedef struct {
    logic rst, ev, ack, clr;
    logic req, busy, done;
    int   pend;
    logic ovf, tmo;
  } vec_t;
  vec_t tbl [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    bit seen;
    rst = 1'b1; event_in = 1'b0; ack_async = 1'b0; clr_err = 1'b0;

    //          rst ev ack clr  req busy done pend ovf tmo
    tbl[0]  = '{1, 1, 0, 0,    0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0,    0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0,    0, 0, 0, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0,    1, 1, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0,    1, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0,    1, 1, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 1, 0,    1, 1, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 1, 0,    1, 1, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 1, 0,    0, 1, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0,    0, 1, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0,    0, 1, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0,    0, 0, 1, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0,    0, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 0, 0,    0, 0, 0, 1, 0, 0};
    tbl[14] = '{0, 1, 0, 0,    1, 1, 0, 1, 0, 0};
    tbl[15] = '{0, 0, 0, 0,    1, 1, 0, 1, 0, 0};

    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; event_in = tbl[i].ev; ack_async = tbl[i].ack; clr_err = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d.req_out", i),  req_out,     tbl[i].req);
      chk($sformatf("tbl%0d.busy", i),     busy,        tbl[i].busy);
      chk($sformatf("tbl%0d.done", i),     done,        tbl[i].done);
      chk($sformatf("tbl%0d.pending", i),  pending,     tbl[i].pend);
      chk($sformatf("tbl%0d.overflow", i), overflow,    tbl[i].ovf);
      chk($sformatf("tbl%0d.timeout", i),  timeout_err, tbl[i].tmo);
    end

    // Launch-coincident event yields a second handshake.
    event_in = 0;
    run_resp(40, d);
    chk("launch_coincide.dones", d, 2);
    chk("launch_coincide.pending", pending, 0);
    chk("launch_coincide.busy", busy, 0);

    // Saturation: 10 events with no responder; 7 queued plus 1 in flight.
    rst = 1; step(); rst = 0;
    ack_async = 0; event_in = 1;
    for (int i = 0; i < 10; i++) step();
    event_in = 0;
    chk("sat.pending", pending, PMAX);
    chk("sat.overflow", overflow, 1);
    run_resp(150, d);
    chk("sat.dones", d, PMAX + 1);
    chk("sat.pending_end", pending, 0);
    chk("sat.overflow_held", overflow, 1);
    clr_err = 1; step(); clr_err = 0;
    chk("sat.overflow_clr", overflow, 0);
    chk("sat.timeout_clr", timeout_err, 0);

    // Timeout: ack never rises.
    rst = 1; step(); rst = 0;
    ack_async = 0;
    event_in = 1; step(); event_in = 0;
    step();
    chk("tmo.req_launched", req_out, 1);
    for (int i = 0; i < TMO - 1; i++) step();
    chk("tmo.not_yet", timeout_err, 0);
    step();
    chk("tmo.set", timeout_err, 1);
    for (int i = 0; i < 5; i++) step();
    chk("tmo.req_held", req_out, 1);
    chk("tmo.still_set", timeout_err, 1);
    ack_async = 1;
    for (int i = 0; i < 6 && req_out; i++) step();
    chk("tmo.late_ack_req_fell", req_out, 0);
    ack_async = 0;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      step();
      if (done) seen = 1;
    end
    chk("tmo.late_done", seen, 1);
    chk("tmo.sticky", timeout_err, 1);
    clr_err = 1; step(); clr_err = 0;
    chk("tmo.cleared", timeout_err, 0);

    // Reset in REQ, then a stale high ack blocks launch.
    rst = 1; step(); rst = 0;
    event_in = 1; step(); event_in = 0;
    step();
    event_in = 1; step(); event_in = 0;
    chk("rstreq.in_req", req_out, 1);
    chk("rstreq.pend_before", pending, 1);
    ack_async = 1; rst = 1; step(); rst = 0;
    chk("rstreq.req_dropped", req_out, 0);
    chk("rstreq.pend_cleared", pending, 0);
    for (int i = 0; i < 3; i++) step();
    event_in = 1; step(); event_in = 0;
    for (int i = 0; i < 5; i++) step();
    chk("stale_ack.no_launch", req_out, 0);
    chk("stale_ack.pend", pending, 1);
    ack_async = 0;
    for (int i = 0; i < 6 && !req_out; i++) step();
    chk("stale_ack.launch_after_drop", req_out, 1);
    run_resp(20, d);

    // Random traffic against the model.
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 1500; i++) begin
      event_in  = ($urandom % 4) == 0;
      clr_err   = ($urandom % 20) == 0;
      rst       = ($urandom % 300) == 0;
      if (($urandom % 3) == 0) ack_async = req_out;
      if (($urandom % 60) == 0) ack_async = ~ack_async;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
